oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
Sprite-DMA sequencer that sits between the 6502 core and the shared memory bus.
- A CPU write to $4014 latches a source page and stalls the CPU via cpu_rdy.
- The block then owns the bus and copies 256 bytes from {page,00..FF} to the OAM data port $2004, one read/write pair per byte.
- It returns the bus to the CPU when the copy is finished.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA
OAM_DATA_ADDR, 16'h2004, destination write address for every byte
XFER_LEN, 256, bytes per transfer (power of two, max 256)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cpu_addr  in  16  CPU bus address
cpu_wen  in  1  CPU write enable
cpu_wdata  in  8  CPU write data
cpu_rdy  out  1  1 = CPU may advance; 0 = CPU stalled
mem_addr  out  16  address to memory/bus
mem_wen  out  1  write enable to memory/bus
mem_wdata  out  8  write data to memory/bus
mem_rdata  in  8  read data; valid one cycle after address presented
dma_busy  out  1  block owns the bus (state != IDLE)
dma_done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cpu_rdy=1, dma_busy=0, dma_done=0.
  - page=0, idx=0, parity=0.
  - Bus outputs follow the CPU inputs.
- parity flop: toggles every clk while rst=0 and is never cleared except by rst. The first cycle after reset release has parity=0.
- Bus mux:
  - In IDLE, mem_addr/mem_wen/mem_wdata = cpu_addr/cpu_wen/cpu_wdata (combinational).
  - In all other states the DMA drives the bus.
- States:
  - IDLE: on cpu_wen=1 && cpu_addr==DMA_REG_ADDR, the write still passes to the bus that cycle. Latch page<=cpu_wdata, idx<=0, next=HALT.
  - HALT: cpu_rdy=0, mem_wen=0, mem_addr=DMA_REG_ADDR. Next=ALIGN if parity==1, else READ.
  - ALIGN: one dummy cycle, same bus values as HALT. Next=READ.
  - READ: mem_addr={page,idx[7:0]}, mem_wen=0. Next=WRITE.
  - WRITE: mem_addr=OAM_DATA_ADDR, mem_wen=1, mem_wdata=mem_rdata (passthrough, byte from the preceding READ).
    - If idx==XFER_LEN-1: next=IDLE, dma_done<=1 for exactly the first IDLE cycle.
    - Else idx<=idx+1, next=READ.
- cpu_rdy is registered:
  - 0 in every non-IDLE state; 1 again in the IDLE cycle following the last WRITE.
  - Stall = 1 + align + 2*XFER_LEN cycles, i.e. 513 or 514 for XFER_LEN=256.
- dma_busy = (state != IDLE).
- Boundary and simultaneous events:
  - CPU inputs are ignored outside IDLE. A $4014 write presented during DMA neither retriggers nor relatches page.
  - idx is 8 bits. Addresses never cross the page; no carry into page.
  - A trigger in the same cycle as dma_done is legal and starts a new transfer.
  - A write to DMA_REG_ADDR with cpu_wen=0 (a read) does not trigger.
  - rst mid-transfer: abandon immediately, return to reset values. No dma_done pulse.

Optional Feature:
OAM_DMA_STALL_COUNT_EN
- With it: extra output port stall_cycles[15:0]. It increments every clk with cpu_rdy=0, saturates at 16'hFFFF, and is cleared only by rst.
- Without it: the port and counter do not exist. Behaviour is otherwise identical.

Decomposition:
- Package nes_bus_pkg holds:
  - state enum: IDLE, HALT, ALIGN, READ, WRITE.
  - Address constants: DMA_REG_ADDR, OAM_DATA_ADDR.
  - The memory read-latency constant (1).
- One natural sub-module: nes_bus_mux. It is combinational; it selects CPU or DMA address/wen/wdata on dma_busy. It is reused later for APU DMC DMA.
- The state machine, idx, page and parity live in oam_dma_ctrl.

Test Plan:
- Trigger on even parity: write 8'h02 to $4014 on a parity=1 cycle (HALT lands on parity=0).
  - Expect no ALIGN; reads from $0200..$02FF in order.
  - Each read is followed by a write to $2004 with the same byte.
  - cpu_rdy low for exactly 513 cycles; single dma_done pulse.
- Odd alignment: same stimulus shifted one cycle.
  - Expect one ALIGN cycle and a 514-cycle stall.
  - Data sequence unchanged.
- Data integrity: preload $0300+i = i^8'hA5 and trigger with page 8'h03.
  - Captured $2004 writes equal i^8'hA5 for i=0..255.
  - No mem_wen=1 to any other address during DMA.
- Ignored retrigger and non-write: during DMA drive cpu_wen=1, cpu_addr=$4014, cpu_wdata=8'h07.
  - Expect the page unchanged and no restart.
  - In IDLE, cpu_addr=$4014 with cpu_wen=0 produces no trigger.
- Reset mid-transfer: assert rst at byte idx=100.
  - Expect immediately cpu_rdy=1, dma_busy=0, no dma_done pulse.
  - Bus passes through CPU inputs.
  - A subsequent trigger restarts from idx=0.
- OAM_DMA_STALL_COUNT_EN defined: two back-to-back DMAs (513 + 514 stall cycles) give stall_cycles=1027.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: DMA state encoding, fixed register addresses
// and memory read latency used by the bus-mastering DMA blocks.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    // Read data appears this many cycles after the address is presented;
    // the READ -> WRITE pairing in the DMA relies on it being 1.
    localparam int unsigned MEM_RD_LATENCY = 1;

endpackage

// File: rtl/nes_bus_mux.sv
// Bus owner select: passes CPU address/wen/wdata to the memory bus unless a
// DMA engine owns the bus, in which case the DMA side is driven instead.
module nes_bus_mux (
    input  logic        dma_sel,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wen,
    input  logic [7:0]  cpu_wdata,
    input  logic [15:0] dma_addr,
    input  logic        dma_wen,
    input  logic [7:0]  dma_wdata,
    output logic [15:0] bus_addr,
    output logic        bus_wen,
    output logic [7:0]  bus_wdata
);

    // Select the bus master
    always_comb begin
        if (dma_sel) begin
            bus_addr  = dma_addr;
            bus_wen   = dma_wen;
            bus_wdata = dma_wdata;
        end else begin
            bus_addr  = cpu_addr;
            bus_wen   = cpu_wen;
            bus_wdata = cpu_wdata;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA sequencer. A CPU write to DMA_REG_ADDR latches a source
// page, stalls the CPU and copies XFER_LEN bytes from {page,idx} to
// OAM_DATA_ADDR, one read/write pair per byte.
// Optional build macro OAM_DMA_STALL_COUNT_EN adds the stall_cycles counter.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wen,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy,
    output logic        dma_done
`ifdef OAM_DMA_STALL_COUNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    import nes_bus_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  state;
    dma_state_t  next_state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        parity;
    logic        trigger;
    logic        last_byte;
    logic [15:0] dma_addr;
    logic        dma_wen;
    logic [7:0]  dma_wdata;

    assign trigger   = cpu_wen && (cpu_addr == DMA_REG_ADDR);
    assign last_byte = (idx == LAST_IDX);
    assign dma_busy  = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; CPU inputs only matter in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = HALT;
            HALT:    next_state = parity ? ALIGN : READ;
            ALIGN:   next_state = READ;
            READ:    next_state = WRITE;
            WRITE:   next_state = last_byte ? IDLE : READ;
            default: next_state = IDLE;
        endcase
    end

    // DMA-side bus values per state
    always_comb begin
        dma_addr  = DMA_REG_ADDR;
        dma_wen   = 1'b0;
        dma_wdata = '0;
        case (state)
            READ: begin
                dma_addr = {page, idx};
            end
            WRITE: begin
                dma_addr  = OAM_DATA_ADDR;
                dma_wen   = 1'b1;
                dma_wdata = mem_rdata;
            end
            default: ;
        endcase
    end

    // Source page latch and byte index; idx wraps within the page
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page <= '0;
            idx  <= '0;
        end else if (state == IDLE && trigger) begin
            page <= cpu_wdata;
            idx  <= '0;
        end else if (state == WRITE && !last_byte) begin
            idx <= idx + 8'd1;
        end
    end

    // Free-running get/put cycle parity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    // Registered CPU ready and one-cycle completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdy  <= 1'b1;
            dma_done <= 1'b0;
        end else begin
            cpu_rdy  <= (next_state == IDLE);
            dma_done <= (state == WRITE) && last_byte;
        end
    end

`ifdef OAM_DMA_STALL_COUNT_EN
    // Saturating count of stalled CPU cycles since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!cpu_rdy && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    nes_bus_mux u_bus_mux (
        .dma_sel   (dma_busy),
        .cpu_addr  (cpu_addr),
        .cpu_wen   (cpu_wen),
        .cpu_wdata (cpu_wdata),
        .dma_addr  (dma_addr),
        .dma_wen   (dma_wen),
        .dma_wdata (dma_wdata),
        .bus_addr  (mem_addr),
        .bus_wen   (mem_wen),
        .bus_wdata (mem_wdata)
    );

endmodule
